// File: rtl/chunked_comparator.sv
// Multi-cycle magnitude comparator: compares CHUNK bits per cycle, MSB chunk first, and stops at
// the first differing chunk. Define COMPARATOR_SIGNED_EN to add the signed_mode port.
module chunked_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             Greater_than,
  output logic             Less_than,
  output logic             Equal
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IdxMax = IDXW'(NCHUNK - 1);

  typedef enum logic [0:0] {StIdle, StCompare} state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [WIDTH-1:0] a_in, b_in;
  logic [CHUNK-1:0] a_chunk, b_chunk;

`ifdef COMPARATOR_SIGNED_EN
  // Flipping both MSBs maps two's-complement order onto unsigned order.
  logic [WIDTH-1:0] msb_flip;
  assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};
  assign a_in     = A ^ msb_flip;
  assign b_in     = B ^ msb_flip;
`else
  assign a_in = A;
  assign b_in = B;
`endif

  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          idx_d   = IdxMax;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (a_chunk > b_chunk) begin
          gt_d    = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (a_chunk < b_chunk) begin
          lt_d    = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy         = (state_q == StCompare);
  assign done         = done_q;
  assign Greater_than = gt_q;
  assign Less_than    = lt_q;
  assign Equal        = eq_q;

endmodule
